// File: rtl/rv_accum_sequencer_if.sv
// Handshake bundle for rv_accum_sequencer: config request, input beats, result slot and status.
interface rv_accum_sequencer_if #(
  parameter int DATAW = 8,
  parameter int ACCW  = 16,
  parameter int MAXN  = 16,
  parameter int WCNTW = 8,
  parameter int LW    = $clog2(MAXN) + 1
);
  logic             cfg_valid;
  logic [LW-1:0]    cfg_len;
  logic [WCNTW-1:0] cfg_windows;
  logic             cfg_ready;
  logic             cfg_err;
  logic             flush;
  logic             in_valid;
  logic [DATAW-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [ACCW-1:0]  out_data;
  logic             out_ready;
  logic             out_sat;
  logic             busy;

  modport master (
    output cfg_valid, cfg_len, cfg_windows, flush, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_err, in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  cfg_valid, cfg_len, cfg_windows, flush, in_valid, in_data, out_ready,
    output cfg_ready, cfg_err, in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/rv_accum_sequencer.sv
// Window accumulator for the conv path: sums cfg_len beats per window, emits one sum per window.
// Define RV_ACCUM_SAT_EN for saturating sums with a sticky out_sat flag; otherwise sums wrap.
module rv_accum_sequencer #(
  parameter int DATAW = 8,
  parameter int ACCW  = 16,
  parameter int MAXN  = 16,
  parameter int WCNTW = 8
) (
  input  logic                clk,
  input  logic                reset,
  rv_accum_sequencer_if.slave bus
);
  localparam int LW = $clog2(MAXN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    len_q, rem;
  logic [WCNTW-1:0] wcnt;
  logic [ACCW-1:0]  acc, acc_sum, out_data_q;
  logic [DATAW-1:0] in_beat;
  logic             cfg_err_q;
  logic             cfg_ok, cfg_take, cfg_bad, beat, last_beat, res_take, flush_act;
  logic             cfg_ready_c, in_ready_c, out_valid_c, busy_c;

  assign in_beat   = bus.in_data;
  assign cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAXN)) && (bus.cfg_windows != '0);
  assign cfg_take  = (state == IDLE) && bus.cfg_valid && cfg_ok;
  assign cfg_bad   = (state == IDLE) && bus.cfg_valid && !cfg_ok;
  // flush outranks both the beat and the result handshake
  assign flush_act = (state != IDLE) && bus.flush;
  assign beat      = (state == RUN) && bus.in_valid && !bus.flush;
  assign last_beat = beat && (rem == LW'(1));
  assign res_take  = (state == HOLD) && bus.out_ready && !bus.flush;

`ifdef RV_ACCUM_SAT_EN
  logic [ACCW:0] sum_ext;
  logic          clamp;
  logic          sat_sticky, out_sat_q;

  always_comb begin
    sum_ext = {1'b0, acc} + (ACCW+1)'(in_beat);
    clamp   = sum_ext[ACCW];
    acc_sum = clamp ? '1 : sum_ext[ACCW-1:0];
  end

  // sticky clamp flag lives for one window; published with the last beat
  always_ff @(posedge clk) begin
    if (reset || cfg_take || res_take || flush_act) begin
      sat_sticky <= 1'b0;
      out_sat_q  <= 1'b0;
    end else if (beat) begin
      sat_sticky <= sat_sticky | clamp;
      if (last_beat) out_sat_q <= sat_sticky | clamp;
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  always_comb begin
    acc_sum = acc + ACCW'(in_beat);
  end

  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cfg_take) state_nxt = RUN;
      RUN: begin
        if (bus.flush)     state_nxt = IDLE;
        else if (last_beat) state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.flush)     state_nxt = IDLE;
        else if (res_take) state_nxt = (wcnt == WCNTW'(1)) ? IDLE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_c = (state == IDLE);
    in_ready_c  = (state == RUN);
    out_valid_c = (state == HOLD);
    busy_c      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      rem        <= '0;
      wcnt       <= '0;
      acc        <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= cfg_bad;
      if (cfg_take) begin
        len_q <= bus.cfg_len;
        rem   <= bus.cfg_len;
        wcnt  <= bus.cfg_windows;
        acc   <= '0;
      end else if (flush_act) begin
        rem        <= '0;
        wcnt       <= '0;
        acc        <= '0;
        out_data_q <= '0;
      end else if (beat) begin
        acc <= acc_sum;
        rem <= rem - LW'(1);
        if (last_beat) out_data_q <= acc_sum;
      end else if (res_take) begin
        wcnt <= wcnt - WCNTW'(1);
        acc  <= '0;
        rem  <= len_q;
      end
    end
  end

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_c;
endmodule

// File: tb/tb_rv_accum_sequencer.sv
// Scoreboard bench for rv_accum_sequencer (ACCW=8 so wrap/saturation is reachable).
module tb_rv_accum_sequencer;
  localparam int DATAW = 8;
  localparam int ACCW  = 8;
  localparam int MAXN  = 16;
  localparam int WCNTW = 8;
  localparam int LW    = $clog2(MAXN) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_accum_sequencer_if #(.DATAW(DATAW), .ACCW(ACCW), .MAXN(MAXN), .WCNTW(WCNTW)) bus ();

  rv_accum_sequencer #(.DATAW(DATAW), .ACCW(ACCW), .MAXN(MAXN), .WCNTW(WCNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   dir_beats[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low, 3: driven by main

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: window sum from the beat list with plain integer arithmetic.
  function automatic exp_t window_result(input int beats[$]);
    exp_t r;
    int   s;
    s     = 0;
    r.sat = 1'b0;
    foreach (beats[i]) begin
      s = s + beats[i];
`ifdef RV_ACCUM_SAT_EN
      if (s > (2**ACCW) - 1) begin
        s     = (2**ACCW) - 1;
        r.sat = 1'b1;
      end
`else
      s = s % (2**ACCW);
`endif
    end
    r.data = s;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (bus.busy && c < 2000) begin
      tick();
      c++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
  endtask

  task automatic send_cfg(input int len, input int nwin);
    bus.cfg_valid   = 1'b1;
    bus.cfg_len     = LW'(len);
    bus.cfg_windows = WCNTW'(nwin);
    tick();
    bus.cfg_valid   = 1'b0;
  endtask

  task automatic send_one(input int v, output bit ok);
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = DATAW'(v);
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic run_windows(input int len, input int nwin, input bit gaps, input bit push);
    int beats[$];
    int v;
    bit ok;
    for (int w = 0; w < nwin; w++) begin
      beats.delete();
      for (int b = 0; b < len; b++) begin
        if (dir_beats.size() > 0) v = dir_beats.pop_front();
        else                      v = int'($urandom_range(0, (2**DATAW) - 1));
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        send_one(v, ok);
        if (!ok) return;
        beats.push_back(v);
      end
      if (push) exp_q.push_back(window_result(beats));
    end
  endtask

  task automatic bad_cfg(input string name, input int len, input int nwin);
    send_cfg(len, nwin);
    @(negedge clk);
    check({name, "_err"}, bus.cfg_err, 1);
    check({name, "_busy"}, bus.busy, 0);
    tick();
    @(negedge clk);
    check({name, "_err_fall"}, bus.cfg_err, 0);
    tick();
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      tick();
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // monitor: every accepted result is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !bus.flush && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", bus.out_data, -1);
        end else begin
          e = exp_q.pop_front();
          check("result_data", bus.out_data, e.data);
          check("result_sat", bus.out_sat, e.sat);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int c;
    bit ok;
    int tmp[$];
    int len, nwin;

    bus.cfg_valid   = 1'b0;
    bus.cfg_len     = '0;
    bus.cfg_windows = '0;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    reset           = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_out_data", bus.out_data, 0);
    tick();

    // basic window, latency and return to idle
    ready_mode = 0;
    send_cfg(4, 1);
    dir_beats = {1, 2, 3, 4};
    run_windows(4, 1, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_latency", bus.out_valid, 1);
    tick();
    @(negedge clk);
    check("t1_idle", bus.busy, 0);
    tick();

    // back-pressure on the first of two windows
    wait_idle();
    ready_mode = 2;
    send_cfg(3, 2);
    dir_beats = {5, 5, 5, 7, 7, 7};
    fork
      run_windows(3, 2, 1'b0, 1'b1);
      begin
        c = 0;
        while (!bus.out_valid && c < 100) begin
          @(negedge clk);
          c++;
        end
        check("t2_hold_seen", bus.out_valid, 1);
        repeat (5) begin
          check("t2_in_ready_hold", bus.in_ready, 0);
          check("t2_out_valid_hold", bus.out_valid, 1);
          check("t2_out_data_hold", bus.out_data, 15);
          @(negedge clk);
        end
        ready_mode = 0;
      end
    join
    wait_idle();

    // illegal configurations
    bad_cfg("t3_len0", 0, 1);
    bad_cfg("t3_len17", 17, 1);
    bad_cfg("t3_win0", 3, 0);

    // flush mid-window, with a beat offered in the same cycle
    send_cfg(4, 1);
    send_one(50, ok);
    send_one(60, ok);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_flush_out_valid", bus.out_valid, 0);
    check("t4_flush_busy", bus.busy, 0);
    check("t4_flush_cfg_ready", bus.cfg_ready, 1);
    tick();
    send_cfg(2, 1);
    dir_beats = {9, 1};
    run_windows(2, 1, 1'b0, 1'b1);
    wait_idle();

    // flush in HOLD beats a same-cycle out_ready; result is dropped
    ready_mode    = 3;
    bus.out_ready = 1'b0;
    send_cfg(1, 2);
    dir_beats = {7};
    run_windows(1, 1, 1'b0, 1'b0);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("flush_hold_busy", bus.busy, 0);
    check("flush_hold_out_valid", bus.out_valid, 0);
    tick();
    ready_mode = 0;

    // flush in IDLE does nothing
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_cfg_ready", bus.cfg_ready, 1);
    check("idle_flush_busy", bus.busy, 0);
    tick();

    // config request during RUN is ignored without an error
    send_cfg(3, 1);
    send_one(4, ok);
    bus.cfg_valid   = 1'b1;
    bus.cfg_len     = '0;
    bus.cfg_windows = '0;
    tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("run_cfg_err", bus.cfg_err, 0);
    check("run_cfg_busy", bus.busy, 1);
    check("run_cfg_ready", bus.cfg_ready, 0);
    tick();
    send_one(5, ok);
    send_one(6, ok);
    tmp = {4, 5, 6};
    exp_q.push_back(window_result(tmp));
    wait_idle();

    // overflow: wrap or clamp
    send_cfg(2, 1);
    dir_beats = {200, 100};
    run_windows(2, 1, 1'b0, 1'b1);
    @(negedge clk);
`ifdef RV_ACCUM_SAT_EN
    check("t5_data", bus.out_data, 255);
    check("t5_sat", bus.out_sat, 1);
`else
    check("t5_data", bus.out_data, 44);
    check("t5_sat", bus.out_sat, 0);
`endif
    tick();
    wait_idle();

    // reset while a result is held
    ready_mode = 2;
    send_cfg(2, 1);
    dir_beats = {10, 20};
    run_windows(2, 1, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_hold", bus.out_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_cfg_ready", bus.cfg_ready, 1);
    check("t6_out_data", bus.out_data, 0);
    check("t6_busy", bus.busy, 0);
    tick();

    // randomized jobs with input gaps and random back-pressure
    ready_mode = 1;
    for (int j = 0; j < 25; j++) begin
      len  = int'($urandom_range(1, MAXN));
      nwin = int'($urandom_range(1, 3));
      wait_idle();
      send_cfg(len, nwin);
      run_windows(len, nwin, 1'b1, 1'b1);
    end
    wait_idle();
    ready_mode = 0;
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
